io_responder: RTL and testbench

IO_RESPONDER -- requirements
Module: io_responder

---
 rtl/io_responder_pkg.sv | 8 +
 rtl/io_responder_fifo_byte.sv | 41 ++++
 rtl/io_responder.sv | 74 +++++++
 tb/tb_io_responder.sv | 150 +++++++++++++++
 4 files changed

// File: rtl/io_responder_pkg.sv
// io_responder_pkg: shared I/O map constants and byte bus type for the I/O responder
package io_responder_pkg;
    localparam int BYTE_W = 8;
    typedef logic [BYTE_W-1:0] byte_bus_t;
    localparam logic [1:0] IO_BASE  = 2'b11;
    localparam logic [2:0] OFF_DATA = 3'd0;
    localparam logic [2:0] OFF_TIME = 3'd4;
endpackage

// File: rtl/io_responder_fifo_byte.sv
// fifo_byte: circular byte FIFO; push/pop in, head/full/empty/dropped out (dropped = push refused while full)
module fifo_byte
    import io_responder_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic      clock,
    input  logic      reset,
    input  logic      push,
    input  logic      pop,
    input  byte_bus_t din,
    output byte_bus_t head,
    output logic      full,
    output logic      empty,
    output logic      dropped
);
    localparam int AW = $clog2(DEPTH);
    byte_bus_t mem [DEPTH];
    logic [AW-1:0] rp, wp;
    logic [AW:0] cnt;
    logic do_pop, do_push;
    assign empty   = cnt == '0;
    assign full    = cnt == (AW+1)'(DEPTH);
    assign head    = mem[rp];
    assign do_pop  = pop && !empty;
    // a pop in the same cycle frees the slot the push needs
    assign do_push = push && (!full || do_pop);
    assign dropped = push && !do_push;
    always_ff @(posedge clock) begin
        if (reset) begin
            rp  <= '0;
            wp  <= '0;
            cnt <= '0;
        end else begin
            if (do_push) mem[wp] <= din;
            if (do_push) wp <= wp + AW'(1);
            if (do_pop) rp <= rp + AW'(1);
            cnt <= cnt + {{AW{1'b0}}, do_push} - {{AW{1'b0}}, do_pop};
        end
    end
endmodule

// File: rtl/io_responder.sv
// io_responder: memory-mapped UART/timer/stop I/O block answering bus reads one cycle later
// ports: bus (ram_rw, ram_addr, ram_w_data -> ram_r_data, io_hit), uart rx (rx_push, rx_data),
//        uart tx (tx_pop -> tx_valid, tx_data), sticky flags (program_stop, rx_overflow, tx_overflow)
module io_responder
    import io_responder_pkg::*;
#(
    parameter int FIFO_DEPTH = 8
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        ram_rw,
    input  logic [31:0] ram_addr,
    input  byte_bus_t   ram_w_data,
    output byte_bus_t   ram_r_data,
    output logic        io_hit,
    input  logic        rx_push,
    input  byte_bus_t   rx_data,
    input  logic        tx_pop,
    output logic        tx_valid,
    output byte_bus_t   tx_data,
    output logic        program_stop,
    output logic        rx_overflow,
    output logic        tx_overflow
);
    logic [31:0] cnt, snap;
    logic [2:0] off;
    logic io, rd, wr, rx_pop, tx_push, rx_empty, tx_empty, rx_drop, tx_drop;
    logic [1:0] unused_full;
    logic [26:0] unused_addr;
    byte_bus_t rx_head, tx_din, rdata_next;
    assign unused_addr = {ram_addr[31:18], ram_addr[15:3]};
    assign off     = ram_addr[2:0];
    assign io      = ram_addr[17:16] == IO_BASE;
    assign rd      = io && !ram_rw;
    assign wr      = io && ram_rw;
    assign rx_pop  = rd && off == OFF_DATA;
    // a zero data write is dropped; the stop write supplies the terminating NUL instead
    assign tx_push = wr && ((off == OFF_DATA && ram_w_data != '0) || off == OFF_TIME);
    assign tx_din  = off == OFF_TIME ? '0 : ram_w_data;
    assign tx_valid = !tx_empty;
    always_comb begin
        rdata_next = '0;
        if (rd)
            rdata_next = off[2] ? (off[1:0] == 2'd0 ? cnt[7:0] : snap[{off[1:0], 3'b000} +: 8])
                                : (off == OFF_DATA && !rx_empty ? rx_head : '0);
    end
    fifo_byte #(.DEPTH(FIFO_DEPTH)) u_rx (
        .clock(clock), .reset(reset), .push(rx_push), .pop(rx_pop), .din(rx_data),
        .head(rx_head), .full(unused_full[0]), .empty(rx_empty), .dropped(rx_drop)
    );
    fifo_byte #(.DEPTH(FIFO_DEPTH)) u_tx (
        .clock(clock), .reset(reset), .push(tx_push), .pop(tx_pop), .din(tx_din),
        .head(tx_data), .full(unused_full[1]), .empty(tx_empty), .dropped(tx_drop)
    );
    always_ff @(posedge clock) begin
        if (reset) begin
            cnt          <= '0;
            snap         <= '0;
            program_stop <= 1'b0;
            rx_overflow  <= 1'b0;
            tx_overflow  <= 1'b0;
            io_hit       <= 1'b0;
            ram_r_data   <= '0;
        end else begin
            cnt        <= cnt + 32'd1;
            io_hit     <= rd;
            ram_r_data <= rdata_next;
            if (rd && off == OFF_TIME) snap <= cnt;
            if (wr && off == OFF_TIME) program_stop <= 1'b1;
            if (rx_drop) rx_overflow <= 1'b1;
            if (tx_drop) tx_overflow <= 1'b1;
        end
    end
endmodule

// File: tb/tb_io_responder.sv
// tb_io_responder: directed plus random checks of io_responder against a queue-based model
module tb_io_responder;
    localparam int DEPTH = 8;
    logic clock, reset, ram_rw, io_hit, rx_push, tx_pop, tx_valid;
    logic program_stop, rx_overflow, tx_overflow;
    logic [31:0] ram_addr;
    logic [7:0] ram_w_data, ram_r_data, rx_data, tx_data;
    int total = 0;
    int bad = 0;
    logic [7:0] rxq[$];
    logic [7:0] txq[$];
    logic [31:0] m_cnt, m_snap;
    logic [7:0] m_rd;
    logic m_hit, m_stop, m_rxo, m_txo;

    io_responder #(.FIFO_DEPTH(DEPTH)) dut (
        .clock(clock), .reset(reset), .ram_rw(ram_rw), .ram_addr(ram_addr),
        .ram_w_data(ram_w_data), .ram_r_data(ram_r_data), .io_hit(io_hit),
        .rx_push(rx_push), .rx_data(rx_data), .tx_pop(tx_pop), .tx_valid(tx_valid),
        .tx_data(tx_data), .program_stop(program_stop), .rx_overflow(rx_overflow),
        .tx_overflow(tx_overflow)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic model_edge();
        logic io;
        int off;
        if (reset) begin
            rxq.delete(); txq.delete();
            m_cnt = 0; m_snap = 0; m_rd = 0; m_hit = 0;
            m_stop = 0; m_rxo = 0; m_txo = 0;
        end else begin
            io = ram_addr[17:16] == 2'b11;
            off = int'(ram_addr[2:0]);
            m_hit = io && !ram_rw;
            m_rd = 0;
            if (m_hit) begin
                if (off == 0 && rxq.size() > 0) m_rd = rxq[0];
                if (off == 4) m_rd = m_cnt[7:0];
                if (off >= 5) m_rd = 8'(m_snap >> (8 * (off - 4)));
                if (off == 0 && rxq.size() > 0) void'(rxq.pop_front());
                if (off == 4) m_snap = m_cnt;
            end
            if (rx_push) begin
                if (rxq.size() < DEPTH) rxq.push_back(rx_data);
                else m_rxo = 1;
            end
            if (tx_pop && txq.size() > 0) void'(txq.pop_front());
            if (io && ram_rw && ((off == 0 && ram_w_data != 0) || off == 4)) begin
                if (txq.size() < DEPTH) txq.push_back(off == 4 ? 8'h00 : ram_w_data);
                else m_txo = 1;
            end
            if (io && ram_rw && off == 4) m_stop = 1;
            m_cnt = m_cnt + 1;
        end
    endtask

    task automatic tick(input string tag);
        @(posedge clock);
        model_edge();
        #1;
        chk({tag, ".rdata"}, 32'(ram_r_data), 32'(m_rd));
        chk({tag, ".hit"}, 32'(io_hit), 32'(m_hit));
        chk({tag, ".txv"}, 32'(tx_valid), 32'(txq.size() > 0));
        if (txq.size() > 0) chk({tag, ".txd"}, 32'(tx_data), 32'(txq[0]));
        chk({tag, ".stop"}, 32'(program_stop), 32'(m_stop));
        chk({tag, ".rxo"}, 32'(rx_overflow), 32'(m_rxo));
        chk({tag, ".txo"}, 32'(tx_overflow), 32'(m_txo));
    endtask

    task automatic idle();
        reset = 0; ram_rw = 0; ram_addr = 0; ram_w_data = 0;
        rx_push = 0; rx_data = 0; tx_pop = 0;
    endtask

    task automatic bus(input logic rw, input logic [31:0] a, input logic [7:0] d);
        ram_rw = rw; ram_addr = a; ram_w_data = d;
    endtask

    initial begin
        idle();
        reset = 1;
        tick("rst0");
        tick("rst1");
        reset = 0;
        chk("rst.txv_const", 32'(tx_valid), 32'd0);
        bus(1, 32'h30000, 8'h41); tick("wr41");
        bus(1, 32'h30000, 8'h00); tick("wr00");
        idle(); tick("tx_one");
        chk("tx_head41", 32'(tx_data), 32'h41);
        tx_pop = 1; tick("txdrain");
        idle();
        rx_push = 1; rx_data = 8'h10; tick("rx10");
        rx_data = 8'h20; tick("rx20");
        idle();
        bus(0, 32'h30000, 8'h00);
        tick("rd1"); chk("rd1.exp10", 32'(ram_r_data), 32'h10);
        tick("rd2"); chk("rd2.exp20", 32'(ram_r_data), 32'h20);
        tick("rd3"); chk("rd3.exp00", 32'(ram_r_data), 32'h00);
        idle();
        for (int i = 0; i < 300; i++) tick("wait");
        for (int i = 4; i < 8; i++) begin
            bus(0, 32'h30000 + 32'(i), 8'h00);
            tick("snap");
        end
        idle();
        for (int i = 0; i < 9; i++) begin
            bus(1, 32'h30000, 8'(8'h50 + i));
            tick("fill");
        end
        chk("full.txo", 32'(tx_overflow), 32'd1);
        bus(1, 32'h30000, 8'h77); tx_pop = 1; tick("fullpp");
        chk("fullpp.txo_only_once", 32'(tx_overflow), 32'd1);
        idle();
        for (int i = 0; i < 8; i++) begin tx_pop = 1; tick("drain"); end
        idle();
        bus(0, 32'h1FFFF, 8'h00); tick("nonio");
        bus(1, 32'h30002, 8'h99); tick("wr_off2");
        idle(); tick("post_off2");
        bus(1, 32'h30004, 8'h55); tick("stop");
        idle(); tick("stop_hold");
        chk("stop.set", 32'(program_stop), 32'd1);
        bus(0, 32'h30000, 8'h00); rx_push = 1; rx_data = 8'hA5; tick("after_stop");
        idle(); reset = 1; tick("rst_stop");
        reset = 0;
        chk("rst.stop_clr", 32'(program_stop), 32'd0);
        for (int i = 0; i < 500; i++) begin
            reset = $urandom_range(0, 99) == 0;
            ram_rw = 1'($urandom_range(0, 1));
            ram_addr = $urandom_range(0, 3) != 0 ? 32'h30000 | 32'($urandom_range(0, 7)) : $urandom();
            ram_w_data = $urandom_range(0, 3) == 0 ? 8'h00 : 8'($urandom());
            rx_push = $urandom_range(0, 1) == 1;
            rx_data = 8'($urandom());
            tx_pop = $urandom_range(0, 2) == 0;
            tick("rand");
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
